// File: rtl/bit_group_regulator.sv
// Serial-to-parallel bit group regulator: collects mod-sized groups of coded bits, MSB first,
// with a one-entry output buffer. Optional flush input enabled by BIT_GROUP_REGULATOR_FLUSH_EN.
module bit_group_regulator #(
  parameter int MAXW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mod,
  input  logic            in_bit,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [MAXW-1:0] out_data,
  output logic [1:0]      out_mod,
  output logic            out_valid,
  input  logic            out_ready
`ifdef BIT_GROUP_REGULATOR_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  localparam int CNT_W = $clog2(MAXW + 1);

  typedef enum logic [1:0] {COLLECT_FIRST, COLLECT, HOLD} state_t;

  function automatic logic [CNT_W-1:0] gs_of(input logic [1:0] m);
    logic [CNT_W-1:0] g;
    case (m)
      2'd0:    g = CNT_W'(MAXW / 6);
      2'd1:    g = CNT_W'(MAXW / 3);
      2'd2:    g = CNT_W'((2 * MAXW) / 3);
      default: g = CNT_W'(MAXW);
    endcase
    return g;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] gs;
  logic [1:0]       grp_mod;
  logic [MAXW-1:0]  grp_data;

  logic             first;
  logic             take;
  logic             flush_req;
  logic             last_bit;
  logic             complete;
  logic             out_free;
  logic [CNT_W-1:0] gs_cur;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] pos;
  logic [1:0]       mod_cur;
  logic [MAXW-1:0]  base;
  logic [MAXW-1:0]  asm_data;

  // Group assembly: the first bit of a group chooses size and mod and starts from a clean word
  always_comb begin
    in_ready = (state != HOLD);
    first    = (state == COLLECT_FIRST);
    take     = in_valid & in_ready;
    gs_cur   = first ? gs_of(mod) : gs;
    mod_cur  = first ? mod : grp_mod;
    cnt_cur  = first ? '0 : cnt;
    base     = first ? '0 : grp_data;
    pos      = gs_cur - cnt_cur - CNT_W'(1);
    asm_data = take ? (base | ({{(MAXW-1){1'b0}}, in_bit} << pos)) : base;
    last_bit = take && (cnt_cur == gs_cur - CNT_W'(1));
`ifdef BIT_GROUP_REGULATOR_FLUSH_EN
    flush_req = flush && (state == COLLECT) && (cnt != '0);
`else
    flush_req = 1'b0;
`endif
    complete = last_bit | flush_req;
    out_free = ~out_valid | out_ready;
  end

  // Control and output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT_FIRST;
      cnt       <= '0;
      out_data  <= '0;
      out_mod   <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        COLLECT_FIRST, COLLECT: begin
          if (complete) begin
            cnt <= '0;
            if (out_free) begin
              out_data  <= asm_data;
              out_mod   <= mod_cur;
              out_valid <= 1'b1;
              state     <= COLLECT_FIRST;
            end else begin
              state <= HOLD;
            end
          end else if (take) begin
            cnt   <= cnt_cur + CNT_W'(1);
            state <= COLLECT;
          end
        end
        HOLD: begin
          if (out_free) begin
            out_data  <= grp_data;
            out_mod   <= grp_mod;
            out_valid <= 1'b1;
            state     <= COLLECT_FIRST;
          end
        end
        default: state <= COLLECT_FIRST;
      endcase
    end
  end

  // Collector datapath; a new group always starts from a cleared word, so no reset is needed
  always_ff @(posedge clk) begin
    if (state != HOLD && (take || complete)) begin
      grp_data <= asm_data;
      grp_mod  <= mod_cur;
      gs       <= gs_cur;
    end
  end

endmodule

// File: tb/tb_bit_group_regulator.sv
// Directed scoreboard bench for bit_group_regulator; exercises flush when
// BIT_GROUP_REGULATOR_FLUSH_EN is defined.
module tb_bit_group_regulator;

  localparam int MAXW = 18;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      mod = 2'd0;
  logic            in_bit = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [MAXW-1:0] out_data;
  logic [1:0]      out_mod;
  logic            out_valid;
  logic            out_ready = 1'b1;
`ifdef BIT_GROUP_REGULATOR_FLUSH_EN
  logic            flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [MAXW+1:0] exp_q[$];

  always #5 clk = ~clk;

  bit_group_regulator #(.MAXW(MAXW)) dut (
    .clk(clk),
    .rst(rst),
    .mod(mod),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_mod(out_mod),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BIT_GROUP_REGULATOR_FLUSH_EN
    ,
    .flush(flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every delivered word is compared against the oldest expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [MAXW+1:0] e;
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[MAXW-1:0]));
        check("out_mod", 32'(out_mod), 32'(e[MAXW+1:MAXW]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Called at posedge+1; returns at posedge+1 right after the bit transferred
  task automatic send(input logic b, input logic [1:0] m);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_bit = b;
    mod = m;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(input logic [1:0] m_first, input logic [1:0] m_rest,
                            input int gs, input logic [MAXW-1:0] word);
    exp_q.push_back({m_first, word});
    for (int k = 0; k < gs; k++)
      send(word[gs-1-k], (k == 0) ? m_first : m_rest);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_mod", 32'(out_mod), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // mod=0, bits 1,0,0 -> 0x4, valid one cycle after the third bit, for one cycle
    send_group(2'd0, 2'd0, 3, 18'h00004);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h4);
    check("t1_mod", 32'(out_mod), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back groups with a mod change, no stalls allowed
    stalls = 0;
    send_group(2'd3, 2'd3, 18, 18'h2AAAA);
    send_group(2'd0, 2'd0, 3, 18'h00003);
    check("t2_no_stalls", 32'(stalls), 32'd0);
    idle(3);

    // Output stalled: first word held, second group goes to HOLD
    out_ready = 1'b0;
    send_group(2'd1, 2'd1, 6, 18'h00032);
    send_group(2'd1, 2'd1, 6, 18'h00017);
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_hold_in_ready", 32'(in_ready), 32'd0);
    check("t3_held_valid", 32'(out_valid), 32'd1);
    check("t3_held_data", 32'(out_data), 32'h32);
    repeat (3) @(negedge clk);
    check("t3_stable_data", 32'(out_data), 32'h32);
    check("t3_stable_mod", 32'(out_mod), 32'd1);
    check("t3_still_hold", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t3_release_in_ready", 32'(in_ready), 32'd1);
    check("t3_second_data", 32'(out_data), 32'h17);
    check("t3_second_valid", 32'(out_valid), 32'd1);
    idle(3);

    // Mid-group mod change is ignored until the next group
    send_group(2'd0, 2'd2, 3, 18'h00006);
    send_group(2'd2, 2'd2, 12, 18'h00801);
    idle(3);

    // Reset mid-group discards partial bits
    for (int k = 0; k < 5; k++) send(1'b1, 2'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_valid_after_rst", 32'(out_valid), 32'd0);
    check("t5_in_ready_after_rst", 32'(in_ready), 32'd1);
    check("t5_data_after_rst", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    send_group(2'd2, 2'd2, 12, 18'h0000F);
    idle(3);

`ifdef BIT_GROUP_REGULATOR_FLUSH_EN
    // Flush a partial mod=2 group after four ones
    exp_q.push_back({2'd2, 18'h00F00});
    for (int k = 0; k < 4; k++) send(1'b1, 2'd2);
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("t6_flush_valid", 32'(out_valid), 32'd1);
    check("t6_flush_data", 32'(out_data), 32'hF00);
    @(posedge clk);
    #1;
    idle(3);
`endif

    idle(2);
    check("all_words_delivered", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_group_regulator.md
# bit_group_regulator

Streaming, parametrised successor to the interleaver's combinational bit-order regulator. It accepts coded bits serially, one per cycle under a valid/ready handshake. It assembles them into groups whose size is selected by the modulation code, and emits each group as a parallel word in bit-reversed order. It sits between the convolutional-encoder/puncturer output and the interleaver permutation stage in the Tx chain. A one-entry output buffer lets collection of the next group overlap a stalled output.

## Interface
- MAXW, default 18: widest group and output word width; must be a multiple of 6, and 6 or more.
- Group size GS per mod code: 0 → MAXW/6, 1 → MAXW/3, 2 → 2*MAXW/3, 3 → MAXW. With the default this gives 3/6/12/18.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mod  in  2  modulation code; sampled only on the first bit of a group.
- in_bit  in  1  serial coded bit.
- in_valid  in  1  in_bit is valid.
- in_ready  out  1  block accepts in_bit this cycle.
- out_data  out  MAXW  regulated group; bits above GS-1 are zero.
- out_mod  out  2  mod code the group was collected with.
- out_valid  out  1  out_data/out_mod valid.
- out_ready  in  1  downstream accepts the word.
- flush  in  1  present only with the configuration macro (see Configuration).

## Operation
- Transfer on input: in_valid & in_ready. Transfer on output: out_valid & out_ready.
- Collector state machine:
  - COLLECT_FIRST: waiting for bit 0. On transfer, latch mod into grp_mod, derive GS, set cnt=1, place the bit, go to COLLECT.
  - COLLECT: each transfer places the bit and increments cnt. On the transfer with cnt==GS-1 the group is complete.
- Bit placement: the k-th received bit (k=0..GS-1) lands at out_data[GS-1-k]. The first bit goes to the MSB of the group and the last bit to bit 0.
- On completion:
  - If the output buffer is empty, or is being consumed this same cycle, the group is loaded with out_mod=grp_mod and out_valid=1. The state returns to COLLECT_FIRST.
  - Otherwise the block goes to HOLD: the complete group is held in the collector and in_ready=0. When the output buffer frees, the group is loaded and the state goes to COLLECT_FIRST.
- in_ready = 1 in COLLECT_FIRST and COLLECT, and 0 in HOLD.
- Changing mod mid-group has no effect until the next group's first bit.
- out_data, out_mod and out_valid are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_data=0, out_mod=0, out_valid=0, in_ready=1, state=COLLECT_FIRST, cnt=0.
- Latency: out_valid rises the cycle after the last bit of a group transfers.
- Throughput: one bit per cycle sustained with out_ready held high. There are no bubbles between groups, including when mod changes between groups.
- Simultaneous output consume and group completion in the same cycle: the new group is loaded and out_valid stays 1.
- HOLD exits on the cycle out_ready=1. The held word appears the next cycle, and in_ready=1 that same next cycle.
- rst asserted mid-group or mid-HOLD: the partial or held group is discarded and all outputs return to reset values the next cycle.
- in_ready does not depend combinationally on in_valid. It may depend combinationally on out_ready.

## Configuration
- BIT_GROUP_REGULATOR_FLUSH_EN defined:
  - The flush input exists.
  - flush=1 in COLLECT with cnt>0 completes the partial group that cycle, leaving the missing low positions as 0. The group then follows the normal completion path, including HOLD.
  - flush in COLLECT_FIRST or HOLD is ignored.
  - If in_valid and flush are both 1, the bit is accepted first, then the group is completed.
- Not defined: no flush port. Partial groups persist until filled or reset.

## Test plan
- Reset, then mod=0, bits 1,0,0, out_ready=1 → one cycle after the 3rd bit: out_data=0x00004 (bits [2:0]=100), out_mod=0, out_valid=1 for one cycle.
- mod=3, 18 bits 1,0,1,0,... → out_data=0x2AAAA (bit17=1, bit16=0, …); zero idle cycles between back-to-back groups.
- out_ready=0, then two mod=1 groups of 6 bits → first word held stable, second group enters HOLD with in_ready=0. Raise out_ready → words delivered in order, in_ready returns to 1.
- mod toggled 0→2 after the first bit of a mod=0 group → group size stays 3 and out_mod=0. The next group uses 12 bits and out_mod=2.
- rst pulsed after 5 of 12 bits → out_valid=0. A following full 12-bit group produces exactly one correct word with no stale bits.
- With BIT_GROUP_REGULATOR_FLUSH_EN: mod=2, 4 bits 1,1,1,1 then flush → out_data=0xF00, out_mod=2.
